// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters advanced by a pixel strobe,
// with registered sync, active-area, coordinate and end-of-line/frame pulse outputs.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_pix_stb,
    output logic          h_sync,
    output logic          v_sync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          end_of_line,
    output logic          end_of_frame,
    output logic          animate,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST_VIS = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] H_VIS_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG     = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG     = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt_reg, h_cnt_next;
    logic [CW-1:0] v_cnt_reg, v_cnt_next;
    logic [7:0]    frame_cnt_reg, frame_cnt_next;

    logic h_last, v_last, v_last_vis;
    logic h_vis, v_vis, hs_region, vs_region;

    always_comb begin
        h_last     = (h_cnt_reg == H_LAST);
        v_last     = (v_cnt_reg == V_LAST);
        v_last_vis = (v_cnt_reg == V_LAST_VIS);
        h_vis      = (h_cnt_reg < H_VIS_END);
        v_vis      = (v_cnt_reg < V_VIS_END);
        hs_region  = (h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END);
        vs_region  = (v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END);
    end

    // Wrap happens on the terminal strobe itself so a line is exactly H_TOTAL strobes.
    always_comb begin
        h_cnt_next     = h_cnt_reg;
        v_cnt_next     = v_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        if (i_pix_stb) begin
            if (h_last) begin
                h_cnt_next = '0;
                if (v_last) begin
                    v_cnt_next     = '0;
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                end else begin
                    v_cnt_next = v_cnt_reg + CW'(1);
                end
            end else begin
                h_cnt_next = h_cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg     <= '0;
            v_cnt_reg     <= '0;
            frame_cnt_reg <= '0;
        end else begin
            h_cnt_reg     <= h_cnt_next;
            v_cnt_reg     <= v_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // Outputs decode the pre-edge counters every clk; pulses only on qualifying strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sync       <= ~HS_POL;
            v_sync       <= ~VS_POL;
            active       <= 1'b0;
            x            <= '0;
            y            <= '0;
            end_of_line  <= 1'b0;
            end_of_frame <= 1'b0;
            animate      <= 1'b0;
        end else begin
            h_sync       <= hs_region ? HS_POL : ~HS_POL;
            v_sync       <= vs_region ? VS_POL : ~VS_POL;
            active       <= h_vis && v_vis;
            x            <= (h_vis && v_vis) ? h_cnt_reg : '0;
            y            <= (h_vis && v_vis) ? v_cnt_reg : '0;
            end_of_line  <= i_pix_stb && h_last;
            end_of_frame <= i_pix_stb && h_last && v_last;
            animate      <= i_pix_stb && h_last && v_last_vis;
        end
    end

    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 line timing plus two tiny
// 7x6 rasters (active-low and active-high sync) for frame-level behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic stb;

    always #5 clk = ~clk;

    logic        d_hs, d_vs, d_act, d_eol, d_eof, d_anim;
    logic [15:0] d_x, d_y;
    logic [7:0]  d_fc;
    logic        s_hs, s_vs, s_act, s_eol, s_eof, s_anim;
    logic [15:0] s_x, s_y;
    logic [7:0]  s_fc;
    logic        p_hs, p_vs, p_act, p_eol, p_eof, p_anim;
    logic [15:0] p_x, p_y;
    logic [7:0]  p_fc;

    int checks = 0;
    int errors = 0;

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .i_pix_stb(stb),
        .h_sync(d_hs), .v_sync(d_vs), .active(d_act), .x(d_x), .y(d_y),
        .end_of_line(d_eol), .end_of_frame(d_eof), .animate(d_anim), .frame_cnt(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .i_pix_stb(stb),
        .h_sync(s_hs), .v_sync(s_vs), .active(s_act), .x(s_x), .y(s_y),
        .end_of_line(s_eol), .end_of_frame(s_eof), .animate(s_anim), .frame_cnt(s_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .i_pix_stb(stb),
        .h_sync(p_hs), .v_sync(p_vs), .active(p_act), .x(p_x), .y(p_y),
        .end_of_line(p_eol), .end_of_frame(p_eof), .animate(p_anim), .frame_cnt(p_fc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release lands 1 ns after a posedge, so the next posedge is strobe edge 1.
    task automatic do_reset();
        rst_n = 1'b0;
        stb   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stb   = 1'b1;
        tick();
        tick();
        checks++; if (d_hs !== 1'b1) begin errors++; $display("FAIL reset_h_sync got %b want 1", d_hs); end
        checks++; if (d_vs !== 1'b1) begin errors++; $display("FAIL reset_v_sync got %b want 1", d_vs); end
        checks++; if (d_act !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", d_act); end
        checks++; if (d_x !== 16'd0 || d_y !== 16'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", d_x, d_y); end
        checks++; if ({d_eol, d_eof, d_anim} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {d_eol, d_eof, d_anim}); end
        checks++; if (d_fc !== 8'd0 || s_fc !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d,%0d want 0,0", d_fc, s_fc); end
        checks++; if ({p_hs, p_vs} !== 2'b00) begin errors++; $display("FAIL reset_pos_sync got %b want 00", {p_hs, p_vs}); end
        $display("test_reset: reset levels sampled with strobe held high");
    endtask

    task automatic test_default_line();
        int lo0 = 0, lo1 = 0, first_lo = 0, act0 = 0;
        int eol_n = 0, eol_first = 0, vs_lo = 0, eof_n = 0;
        logic [15:0] x639 = '0, x640 = '1, y801 = '0;
        logic a801 = 1'b0;
        do_reset();
        stb = 1'b1;
        for (int k = 1; k <= 1600; k++) begin
            tick();
            if (!d_hs) begin
                if (k <= 800) lo0++; else lo1++;
                if (first_lo == 0) first_lo = k;
            end
            if (k <= 800 && d_act) act0++;
            if (d_eol) begin eol_n++; if (eol_first == 0) eol_first = k; end
            if (!d_vs) vs_lo++;
            if (d_eof) eof_n++;
            if (k == 640) x639 = d_x;
            if (k == 641) x640 = d_x;
            if (k == 801) begin y801 = d_y; a801 = d_act; end
        end
        checks++; if (lo0 !== 96) begin errors++; $display("FAIL hsync_width_line0 got %0d want 96", lo0); end
        checks++; if (lo1 !== 96) begin errors++; $display("FAIL hsync_width_line1 got %0d want 96", lo1); end
        checks++; if (first_lo !== 657) begin errors++; $display("FAIL hsync_start got edge %0d want 657", first_lo); end
        checks++; if (act0 !== 640) begin errors++; $display("FAIL active_count got %0d want 640", act0); end
        checks++; if (eol_n !== 2) begin errors++; $display("FAIL eol_count got %0d want 2", eol_n); end
        checks++; if (eol_first !== 800) begin errors++; $display("FAIL line_period got %0d want 800", eol_first); end
        checks++; if (vs_lo !== 0) begin errors++; $display("FAIL vsync_idle got %0d low want 0", vs_lo); end
        checks++; if (eof_n !== 0) begin errors++; $display("FAIL eof_early got %0d want 0", eof_n); end
        checks++; if (x639 !== 16'd639) begin errors++; $display("FAIL x_last_visible got %0d want 639", x639); end
        checks++; if (x640 !== 16'd0) begin errors++; $display("FAIL x_blank got %0d want 0", x640); end
        checks++; if (y801 !== 16'd1 || a801 !== 1'b1) begin errors++; $display("FAIL y_line1 got %0d/%b want 1/1", y801, a801); end
        $display("test_default_line: two 800-strobe lines at default timing");
    endtask

    task automatic test_small_frame();
        int exp_x [7] = '{0, 1, 2, 3, 0, 0, 0};
        logic [15:0] xs [7];
        int anim_n = 0, anim_first = 0, eof_n = 0, eof_first = 0, eof_last = 0;
        int eof_no_eol = 0, vs_lo = 0, pvs_hi = 0, phs_hi = 0;
        logic [15:0] y16 = '0;
        do_reset();
        stb = 1'b1;
        for (int k = 1; k <= 84; k++) begin
            tick();
            if (k <= 7) xs[k-1] = s_x;
            if (s_anim) begin anim_n++; if (anim_first == 0) anim_first = k; end
            if (s_eof) begin
                eof_n++;
                if (eof_first == 0) eof_first = k;
                eof_last = k;
                if (!s_eol) eof_no_eol++;
            end
            if (k <= 42 && !s_vs) vs_lo++;
            if (k <= 42 && p_vs) pvs_hi++;
            if (k <= 42 && p_hs) phs_hi++;
            if (k == 16) y16 = s_y;
        end
        for (int i = 0; i < 7; i++) begin
            checks++; if (xs[i] !== 16'(exp_x[i])) begin errors++; $display("FAIL x_seq[%0d] got %0d want %0d", i, xs[i], exp_x[i]); end
        end
        checks++; if (anim_n !== 2) begin errors++; $display("FAIL animate_count got %0d want 2", anim_n); end
        checks++; if (anim_first !== 21) begin errors++; $display("FAIL animate_pos got %0d want 21", anim_first); end
        checks++; if (eof_n !== 2) begin errors++; $display("FAIL eof_count got %0d want 2", eof_n); end
        checks++; if (eof_first !== 42 || eof_last !== 84) begin errors++; $display("FAIL eof_period got %0d,%0d want 42,84", eof_first, eof_last); end
        checks++; if (eof_no_eol !== 0) begin errors++; $display("FAIL eof_without_eol got %0d want 0", eof_no_eol); end
        checks++; if (vs_lo !== 7) begin errors++; $display("FAIL small_vsync_width got %0d want 7", vs_lo); end
        checks++; if (pvs_hi !== 7) begin errors++; $display("FAIL pos_vsync_width got %0d want 7", pvs_hi); end
        checks++; if (phs_hi !== 6) begin errors++; $display("FAIL pos_hsync_pulses got %0d want 6", phs_hi); end
        checks++; if (y16 !== 16'd2) begin errors++; $display("FAIL y_row2 got %0d want 2", y16); end
        checks++; if (s_fc !== 8'd2) begin errors++; $display("FAIL small_frame_cnt got %0d want 2", s_fc); end
        $display("test_small_frame: two 42-strobe frames on the 7x6 raster");
    endtask

    task automatic test_strobe_div();
        int eof_n = 0, eof_c1 = -1, eof_c2 = -1, eol_n = 0, chg = 0, bad = 0;
        logic [15:0] prev_x;
        do_reset();
        for (int c = 0; c < 336; c++) begin
            stb = (c % 4 == 0);
            prev_x = s_x;
            tick();
            if (s_eof) begin
                eof_n++;
                if (eof_c1 < 0) eof_c1 = c; else eof_c2 = c;
            end
            if (s_eol) eol_n++;
            if (s_x !== prev_x) begin
                chg++;
                if (c % 4 != 1) bad++;
            end
        end
        stb = 1'b0;
        checks++; if (eof_n !== 2) begin errors++; $display("FAIL div_eof_count got %0d want 2", eof_n); end
        checks++; if (eof_c1 !== 164 || eof_c2 !== 332) begin errors++; $display("FAIL div_eof_pos got %0d,%0d want 164,332", eof_c1, eof_c2); end
        checks++; if (eol_n !== 12) begin errors++; $display("FAIL div_eol_count got %0d want 12", eol_n); end
        checks++; if (chg !== 24) begin errors++; $display("FAIL div_x_changes got %0d want 24", chg); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL div_x_between_strobes got %0d want 0", bad); end
        checks++; if (s_fc !== 8'd2) begin errors++; $display("FAIL div_frame_cnt got %0d want 2", s_fc); end
        $display("test_strobe_div: one strobe every four clocks for two frames");
    endtask

    task automatic test_async_reset();
        logic [15:0] x1 = '1, x2 = '0;
        int eol_first = 0, eof_first = 0;
        do_reset();
        stb = 1'b1;
        for (int k = 1; k <= 300; k++) tick();
        checks++; if (d_x !== 16'd299) begin errors++; $display("FAIL pre_reset_x got %0d want 299", d_x); end
        checks++; if (s_fc !== 8'd7 || p_hs !== 1'b1) begin errors++; $display("FAIL pre_reset_state got fc %0d hs %b want 7,1", s_fc, p_hs); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (d_x !== 16'd0 || d_act !== 1'b0) begin errors++; $display("FAIL async_xy got %0d/%b want 0/0", d_x, d_act); end
        checks++; if (s_fc !== 8'd0 || p_hs !== 1'b0) begin errors++; $display("FAIL async_state got fc %0d hs %b want 0,0", s_fc, p_hs); end
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            tick();
            if (k == 1) x1 = d_x;
            if (k == 2) x2 = d_x;
            if (d_eol && eol_first == 0) eol_first = k;
            if (s_eof && eof_first == 0) eof_first = k;
        end
        checks++; if (x1 !== 16'd0 || x2 !== 16'd1) begin errors++; $display("FAIL restart_x got %0d,%0d want 0,1", x1, x2); end
        checks++; if (eol_first !== 800) begin errors++; $display("FAIL restart_line got %0d want 800", eol_first); end
        checks++; if (eof_first !== 42) begin errors++; $display("FAIL restart_frame got %0d want 42", eof_first); end
        $display("test_async_reset: reset pulsed between clock edges mid-frame");
    endtask

    task automatic test_frame_wrap();
        int n_eof = 0;
        logic [7:0] fc255 = '0, fc256 = '1, fc_before = '0;
        do_reset();
        stb = 1'b1;
        for (int k = 1; k <= 256 * 42; k++) begin
            tick();
            if (s_eof) begin
                n_eof++;
                if (n_eof == 255) fc255 = s_fc;
                if (n_eof == 256) fc256 = s_fc;
            end
            if (k == 256 * 42 - 1) fc_before = s_fc;
        end
        checks++; if (n_eof !== 256) begin errors++; $display("FAIL wrap_eof_count got %0d want 256", n_eof); end
        checks++; if (fc255 !== 8'd255) begin errors++; $display("FAIL wrap_fc_255 got %0d want 255", fc255); end
        checks++; if (fc_before !== 8'd255) begin errors++; $display("FAIL wrap_fc_before got %0d want 255", fc_before); end
        checks++; if (fc256 !== 8'd0) begin errors++; $display("FAIL wrap_fc_256 got %0d want 0", fc256); end
        $display("test_frame_wrap: 256 frames on the 7x6 raster");
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_small_frame();
        test_strobe_div();
        test_async_reset();
        test_frame_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
